// File: rtl/final_project_cmd_pio.sv
// Avalon-MM command PIO: software pushes command words into a show-ahead FIFO that
// fabric logic drains over a valid/ready stream; status is readable at addr1.
module final_project_cmd_pio #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   readdata_q, readdata_d;
    logic [31:0]   status;

    logic wr, push, ctrl, pop, flush, clr_ovf, push_ok;
    logic full, empty;
    logic unused_wdata;

    assign wr      = chipselect & ~write_n;
    assign push    = wr & (address == 2'd0);
    assign ctrl    = wr & (address == 2'd2);
    assign flush   = ctrl & writedata[1];
    assign clr_ovf = ctrl & writedata[0];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr_q];
    assign pop       = out_valid & out_ready;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop) & ~flush;

    assign unused_wdata = ^writedata;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop);
        end
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end else if (push & full & ~pop) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        status         = '0;
        status[0]      = empty;
        status[1]      = full;
        status[2]      = overflow_q;
        status[8 +: CW] = count_q;
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            2'd1:    readdata_d = status;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
        end
    end

    // Storage carries no reset; stale entries are never visible once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= writedata[DATA_WIDTH-1:0];
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_final_project_cmd_pio.sv
// Directed self-checking bench for final_project_cmd_pio with hand-computed expectations.
module tb_final_project_cmd_pio;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    final_project_cmd_pio #(
        .DATA_WIDTH(16),
        .DEPTH     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
    endtask

    task automatic rd_check(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        tick();
        chk(tag, readdata, exp);
        address = 2'd0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        rd_check(2'd1, "status_after_reset", 32'h0000_0001);

        // Two words, then drain them.
        wr_word(2'd0, 32'hFFFF_1234);
        wr_word(2'd0, 32'h0000_0056);
        chk("two_valid", 32'(out_valid), 32'd1);
        chk("two_head", 32'(out_data), 32'h1234);
        rd_check(2'd1, "status_two", 32'h0000_0200);
        rd_check(2'd3, "reserved_read", 32'h0);
        rd_check(2'd0, "data_reg_read", 32'h0);
        chk("hold_head", 32'(out_data), 32'h1234);
        out_ready = 1'b1;
        tick();
        chk("second_head", 32'(out_data), 32'h0056);
        tick();
        out_ready = 1'b0;
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_data", 32'(out_data), 32'd0);

        // Overfill: 17 writes, the 17th is dropped.
        for (int i = 0; i < 17; i++) wr_word(2'd0, 32'(i));
        rd_check(2'd1, "status_overflow", 32'h0000_1006);
        chk("full_head", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("after_drain_valid", 32'(out_valid), 32'd0);
        rd_check(2'd1, "status_sticky_ovf", 32'h0000_0005);
        wr_word(2'd2, 32'h1);
        rd_check(2'd1, "status_ovf_cleared", 32'h0000_0001);

        // Push while full with a simultaneous pop is accepted.
        for (int i = 0; i < 16; i++) wr_word(2'd0, 32'h100 + 32'(i));
        rd_check(2'd1, "status_full", 32'h0000_1002);
        out_ready = 1'b1;
        wr_word(2'd0, 32'hBEEF);
        out_ready = 1'b0;
        rd_check(2'd1, "status_full_no_ovf", 32'h0000_1002);
        chk("head_after_pushpop", 32'(out_data), 32'h101);
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) tick();
        chk("beef_last", 32'(out_data), 32'hBEEF);
        tick();
        out_ready = 1'b0;
        chk("beef_drained", 32'(out_valid), 32'd0);

        // Flush alone keeps overflow; flush+clear with a concurrent pop empties everything.
        for (int i = 0; i < 17; i++) wr_word(2'd0, 32'h200 + 32'(i));
        wr_word(2'd2, 32'h2);
        rd_check(2'd1, "status_flush_keeps_ovf", 32'h0000_0005);
        wr_word(2'd0, 32'hA);
        wr_word(2'd0, 32'hB);
        wr_word(2'd0, 32'hC);
        chk("three_head", 32'(out_data), 32'hA);
        out_ready = 1'b1;
        wr_word(2'd2, 32'h3);
        out_ready = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", 32'(out_data), 32'd0);
        rd_check(2'd1, "status_flushed", 32'h0000_0001);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 5; i++) wr_word(2'd0, 32'h50 + 32'(i));
        rd_check(2'd1, "status_five", 32'h0000_0500);
        out_ready = 1'b1;
        tick();
        tick();
        chk("mid_drain_head", 32'(out_data), 32'h52);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        chk("async_rst_readdata", readdata, 32'd0);
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        rd_check(2'd1, "status_after_async_rst", 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
